// File: rtl/regfile_arbiter.sv
// Two-master round-robin arbiter sequencing single-cycle accesses into the
// peripheral register block, returning read data / error to the granted master.
module regfile_arbiter #(
    parameter int unsigned ADDR_MAX = 12
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_r_wn,
    input  logic [5:2]  m0_addr,
    input  logic [3:0]  m0_wben,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_r_wn,
    input  logic [5:2]  m1_addr,
    input  logic [3:0]  m1_wben,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,

    output logic [5:2]  rf_addr,
    output logic [3:0]  rf_wben,
    output logic        rf_r_wn,
    output logic [31:0] rf_wdata,
    input  logic [31:0] rf_rdata,

    output logic        busy
);

    localparam logic [3:0] LP_ADDR_MAX = ADDR_MAX[3:0];

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_last_grant;
    logic        r_mask;
    logic        r_winner;
    logic        r_r_wn;
    logic        r_err;

    logic        w_elig0;
    logic        w_elig1;
    logic        w_win_valid;
    logic        w_winner;
    logic        w_sel_r_wn;
    logic [3:0]  w_sel_addr;
    logic [3:0]  w_sel_wben;
    logic [31:0] w_sel_wdata;
    logic        w_sel_oob;
    logic [31:0] w_capture;

    // The mask only ever blocks the master that won the transaction just completed.
    always_comb begin
        w_elig0     = m0_req && !(r_mask && !r_last_grant);
        w_elig1     = m1_req && !(r_mask &&  r_last_grant);
        w_win_valid = w_elig0 || w_elig1;
        w_winner    = (w_elig0 && w_elig1) ? ~r_last_grant : w_elig1;
        w_sel_r_wn  = w_winner ? m1_r_wn  : m0_r_wn;
        w_sel_addr  = w_winner ? m1_addr  : m0_addr;
        w_sel_wben  = w_winner ? m1_wben  : m0_wben;
        w_sel_wdata = w_winner ? m1_wdata : m0_wdata;
        w_sel_oob   = (w_sel_addr > LP_ADDR_MAX);
        w_capture   = (r_r_wn && !r_err) ? rf_rdata : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_mask       <= 1'b0;
            r_winner     <= 1'b0;
            r_r_wn       <= 1'b1;
            r_err        <= 1'b0;
            m0_ack       <= 1'b0;
            m0_err       <= 1'b0;
            m0_rdata     <= '0;
            m1_ack       <= 1'b0;
            m1_err       <= 1'b0;
            m1_rdata     <= '0;
            rf_addr      <= '0;
            rf_wben      <= '0;
            rf_r_wn      <= 1'b1;
            rf_wdata     <= '0;
            busy         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_mask <= 1'b0;
                    if (w_win_valid) begin
                        r_winner     <= w_winner;
                        r_last_grant <= w_winner;
                        r_r_wn       <= w_sel_r_wn;
                        r_err        <= w_sel_oob;
                        // Register-block drive is staged here so it is stable for the whole ACCESS cycle.
                        rf_addr      <= w_sel_addr;
                        rf_wdata     <= w_sel_wdata;
                        rf_r_wn      <= w_sel_oob ? 1'b1 : w_sel_r_wn;
                        rf_wben      <= w_sel_oob ? 4'b0000 : w_sel_wben;
                        busy         <= 1'b1;
                        r_state      <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    rf_r_wn <= 1'b1;
                    rf_wben <= '0;
                    if (r_winner) begin
                        m1_ack   <= 1'b1;
                        m1_err   <= r_err;
                        m1_rdata <= w_capture;
                    end else begin
                        m0_ack   <= 1'b1;
                        m0_err   <= r_err;
                        m0_rdata <= w_capture;
                    end
                    r_state <= ST_DONE;
                end

                ST_DONE: begin
                    m0_ack   <= 1'b0;
                    m0_err   <= 1'b0;
                    m0_rdata <= '0;
                    m1_ack   <= 1'b0;
                    m1_err   <= 1'b0;
                    m1_rdata <= '0;
                    r_mask   <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter: transaction-level arbitration model with
// cycle timestamps, a behavioural register block, directed and random traffic.
module tb_regfile_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  rwn;
    logic [3:0]  addr  [2];
    logic [3:0]  wben  [2];
    logic [31:0] wdata [2];

    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [5:2]  rf_addr;
    logic [3:0]  rf_wben;
    logic        rf_r_wn;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata;
    logic        busy;

    always #5 clk = ~clk;

    regfile_arbiter #(.ADDR_MAX(12)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (req[0]),
        .m0_r_wn  (rwn[0]),
        .m0_addr  (addr[0]),
        .m0_wben  (wben[0]),
        .m0_wdata (wdata[0]),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m0_rdata (m0_rdata),
        .m1_req   (req[1]),
        .m1_r_wn  (rwn[1]),
        .m1_addr  (addr[1]),
        .m1_wben  (wben[1]),
        .m1_wdata (wdata[1]),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .m1_rdata (m1_rdata),
        .rf_addr  (rf_addr),
        .rf_wben  (rf_wben),
        .rf_r_wn  (rf_r_wn),
        .rf_wdata (rf_wdata),
        .rf_rdata (rf_rdata),
        .busy     (busy)
    );

    function automatic logic [31:0] init_val(input int i);
        if (i == 0) return 32'h48524a44;
        return 32'hA5A50000 ^ (32'(i) * 32'h01010101);
    endfunction

    // Behavioural register block, reset together with the system.
    logic [31:0] periph [16];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) periph[i] <= init_val(i);
        end else if (!rf_r_wn) begin
            for (int b = 0; b < 4; b++)
                if (rf_wben[b]) periph[rf_addr][b*8 +: 8] <= rf_wdata[b*8 +: 8];
        end
    end
    assign rf_rdata = periph[rf_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned gap;
        logic        r_wn;
        logic [3:0]  addr;
        logic [3:0]  wben;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        int          m;
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    cmd_t        cq [2][$];
    int unsigned wait_cnt [2];
    exp_t        sb [$];

    // Reference model: grant edge of the latest transaction and its winner.
    int          last_s = -10;
    int          last_w = 1;
    logic [31:0] ref_mem [16];
    logic        acc_wr;
    logic [3:0]  acc_wben;
    logic [3:0]  acc_addr;
    logic [31:0] acc_wdata;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic ref_reset();
        last_s = -10;
        last_w = 1;
        acc_wr = 1'b0;
        acc_wben = '0;
        acc_addr = '0;
        acc_wdata = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    endtask

    task automatic step();
        logic [1:0]  ack;
        logic [1:0]  er;
        logic [31:0] rd [2];
        logic        in_acc;
        logic [1:0]  elig;
        int          e;
        int          w;
        logic        oob;
        logic [31:0] exp_rd;
        exp_t        x;
        cmd_t        c;

        @(negedge clk);
        ack   = {m1_ack, m0_ack};
        er    = {m1_err, m0_err};
        rd[0] = m0_rdata;
        rd[1] = m1_rdata;

        // Monitor: outputs versus scoreboard and model
        chk("ack_both", {31'b0, ack[0] & ack[1]}, 32'd0);
        for (int m = 0; m < 2; m++) begin
            if (ack[m]) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", {31'b0, ack[m]}, 32'd0);
                end else begin
                    x = sb.pop_front();
                    chk("ack_master", m, x.m);
                    chk("ack_cycle", cyc, x.cyc);
                    chk("ack_err", {31'b0, er[m]}, {31'b0, x.err});
                    chk("ack_rdata", rd[m], x.rdata);
                end
            end else begin
                chk("idle_err", {31'b0, er[m]}, 32'd0);
                chk("idle_rdata", rd[m], 32'd0);
            end
        end
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("ack_missing", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        in_acc = (cyc == last_s);
        chk("busy", {31'b0, busy}, {31'b0, (cyc == last_s) || (cyc == last_s + 1)});
        chk("rf_r_wn", {31'b0, rf_r_wn}, in_acc ? {31'b0, !acc_wr} : 32'd1);
        chk("rf_wben", {28'b0, rf_wben}, in_acc ? {28'b0, acc_wben} : 32'd0);
        if (in_acc) begin
            chk("rf_addr", {28'b0, rf_addr}, {28'b0, acc_addr});
            chk("rf_wdata", rf_wdata, acc_wdata);
        end

        // Masters: drop req on ack, then issue queued commands
        for (int m = 0; m < 2; m++) begin
            if (req[m] && ack[m]) req[m] = 1'b0;
            if (!req[m] && cq[m].size() > 0) begin
                if (wait_cnt[m] < cq[m][0].gap) begin
                    wait_cnt[m]++;
                end else begin
                    c = cq[m].pop_front();
                    wait_cnt[m] = 0;
                    req[m]   = 1'b1;
                    rwn[m]   = c.r_wn;
                    addr[m]  = c.addr;
                    wben[m]  = c.wben;
                    wdata[m] = c.wdata;
                end
            end
        end

        // Model: one grant per 3 edges; previous winner sits out the first free edge
        e = cyc + 1;
        if (reset && e >= last_s + 3) begin
            for (int m = 0; m < 2; m++)
                elig[m] = req[m] && !(e == last_s + 3 && m == last_w);
            if (elig != 2'b00) begin
                w = (elig == 2'b11) ? 1 - last_w : (elig[1] ? 1 : 0);
                last_s   = e;
                last_w   = w;
                oob      = (addr[w] > 4'd12);
                acc_wr   = !oob && !rwn[w];
                acc_wben = oob ? 4'b0000 : wben[w];
                acc_addr = addr[w];
                acc_wdata = wdata[w];
                exp_rd   = (!oob && rwn[w]) ? ref_mem[addr[w]] : 32'd0;
                if (acc_wr)
                    for (int b = 0; b < 4; b++)
                        if (wben[w][b]) ref_mem[addr[w]][b*8 +: 8] = wdata[w][b*8 +: 8];
                sb.push_back('{m: w, cyc: e + 1, err: oob, rdata: exp_rd});
            end
        end
    endtask

    task automatic drain(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (cq[0].size() == 0 && cq[1].size() == 0 && req == 2'b00 &&
                sb.size() == 0 && cyc > last_s + 2) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", cyc, 32'd0);
    endtask

    task automatic push(input int m, input int unsigned gap, input logic r_wn,
                        input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
        cq[m].push_back('{gap: gap, r_wn: r_wn, addr: a, wben: be, wdata: d});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit reached;
        reset = 1'b0;
        req = '0;
        rwn = '1;
        for (int m = 0; m < 2; m++) begin
            addr[m] = '0; wben[m] = '0; wdata[m] = '0; wait_cnt[m] = 0;
        end
        ref_reset();

        repeat (3) @(negedge clk);
        chk("rst_rf_r_wn", {31'b0, rf_r_wn}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_acks", {30'b0, m1_ack, m0_ack}, 32'd0);
        chk("rst_rf_addr", {28'b0, rf_addr}, 32'd0);
        chk("rst_rf_wben", {28'b0, rf_wben}, 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        reset = 1'b1;

        push(0, 0, 1'b1, 4'd0, 4'hF, 32'd0);
        drain(50);
        push(1, 0, 1'b0, 4'd6, 4'b0011, 32'hDEADBEEF);
        drain(50);
        push(0, 0, 1'b1, 4'd6, 4'h0, 32'd0);
        drain(50);
        push(0, 0, 1'b0, 4'd13, 4'hF, 32'hCAFEF00D);
        drain(50);
        push(0, 0, 1'b1, 4'd13, 4'h0, 32'd0);
        push(1, 0, 1'b1, 4'd15, 4'h0, 32'd0);
        drain(50);

        for (int i = 0; i < 2; i++) begin
            push(0, 0, 1'b1, 4'(i + 1), 4'h0, 32'd0);
            push(1, 0, 1'b0, 4'(i + 3), 4'hF, 32'h1000 + 32'(i));
        end
        drain(100);
        for (int i = 0; i < 3; i++) push(0, 0, 1'b1, 4'(i + 2), 4'h0, 32'd0);
        drain(100);

        for (int i = 0; i < 200; i++) begin
            push($urandom_range(0, 1),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)),
                 $urandom);
        end
        drain(5000);

        // Abort a write in its access cycle with asynchronous reset
        push(0, 0, 1'b0, 4'd5, 4'hF, 32'h12345678);
        reached = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (cyc == last_s) begin
                reached = 1'b1;
                break;
            end
        end
        if (!reached) chk("reset_access_reach", cyc, 32'd0);
        #1 reset = 1'b0;
        #1;
        chk("abort_rf_r_wn", {31'b0, rf_r_wn}, 32'd1);
        chk("abort_rf_wben", {28'b0, rf_wben}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_ack", {30'b0, m1_ack, m0_ack}, 32'd0);
        req = '0;
        sb.delete();
        ref_reset();
        step();
        step();
        reset = 1'b1;
        step();
        push(0, 0, 1'b1, 4'd5, 4'h0, 32'd0);
        push(1, 0, 1'b1, 4'd5, 4'h0, 32'd0);
        drain(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
Two-master arbiter and access sequencer for the memory-mapped peripheral register block (GPIO/timer control registers). Master 0 is the CPU load/store bus and master 1 is the debug/UART bridge. Each master uses a req/ack handshake. The arbiter serialises accesses round-robin, drives the register block's addr/wben/r_wn/wdata for exactly one access cycle, captures rdata, and returns it to the granted master. Out-of-range register indexes are rejected with an error flag.

Parameters:
ADDR_MAX, 12, highest valid register index (addr[5:2]); larger indexes are rejected.

Ports:
clk  input  1  master clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
m0_req  input  1  master 0 request; held high with stable command until m0_ack
m0_r_wn  input  1  master 0 read(1)/write-not(0)
m0_addr  input  [5:2]  master 0 register index
m0_wben  input  4  master 0 byte write enables
m0_wdata  input  32  master 0 write data
m0_ack  output  1  master 0 completion pulse (1 cycle)
m0_err  output  1  master 0 error, valid while m0_ack=1
m0_rdata  output  32  master 0 read data, valid while m0_ack=1
m1_req, m1_r_wn, m1_addr, m1_wben, m1_wdata, m1_ack, m1_err, m1_rdata  same as m0_*, for master 1
rf_addr  output  [5:2]  register block index
rf_wben  output  4  register block byte enables
rf_r_wn  output  1  register block read/write-not
rf_wdata  output  32  register block write data
rf_rdata  input  32  register block read data (combinational from rf_addr)
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, last_grant=1 (m0 wins the first contention), mask=0.
  - All ack, err and rdata outputs = 0; rf_addr=0, rf_wben=0, rf_r_wn=1, rf_wdata=0, busy=0.
  - Reset during ACCESS aborts the transaction: no ack is issued and rf_r_wn returns to 1 immediately.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE. There is no other path.
- IDLE:
  - rf_r_wn=1, rf_wben=0; rf_addr and rf_wdata hold their last values. No write can occur in IDLE.
  - Eligible requesters are those with reqN=1 that are not masked.
  - If exactly one is eligible, it wins. If both are eligible, the one that is not last_grant wins.
  - On a win: latch the winner's r_wn, addr, wben and wdata; set last_grant=winner; go to ACCESS.
  - If none is eligible, stay in IDLE.
  - mask=1 blocks the previous winner for the first IDLE cycle only, then clears. The other master is never masked.
- ACCESS (exactly 1 cycle):
  - Drive rf_addr/rf_wdata from the latched values.
  - If latched addr <= ADDR_MAX: rf_r_wn = latched r_wn and rf_wben = latched wben. A write is committed at the closing edge.
  - If latched addr > ADDR_MAX: rf_r_wn=1, rf_wben=0 (no write), and set err_q=1.
  - At the closing edge, capture rf_rdata into the winner's rdata register.
    - Writes capture 0.
    - Error accesses capture 0.
  - Go to DONE.
- DONE (1 cycle):
  - Winner's ack=1; err = err_q; rdata = captured value.
  - The loser's ack, err and rdata stay 0.
  - Set mask=1, then go to IDLE.
- Timing:
  - Request-to-ack latency is 2 cycles after the req sample edge.
  - Throughput is 1 transaction per 3 cycles under contention (ping-pong).
  - A single master streaming back-to-back gets 1 transaction per 4 cycles because of the mask cycle.
- ack, err and rdata are registered and are 0 outside the DONE cycle.
- A req deasserted before ack is a protocol violation. The latched command still completes and ack is still issued.
- Writes to read-only indexes are passed through without err; the register block ignores them.

Test Plan:
- Single read: m0_req=1, m0_r_wn=1, m0_addr=0, rf_rdata model=32'h48524a44 -> m0_ack high exactly 2 cycles after the req sample edge, m0_rdata=32'h48524a44, m0_err=0, m1_ack stays 0.
- Byte write: m1 write addr=6, wben=4'b0011, wdata=32'hDEADBEEF -> rf_r_wn=0 for exactly one cycle with rf_addr=6, rf_wben=3; m1_ack pulses, m1_rdata=0.
- Contention: m0 and m1 both request from reset, held continuously -> grant order m0, m1, m0, m1; acks spaced 3 cycles apart; neither master is starved.
- Out of range: m0 write addr=13, wben=4'hF -> rf_wben stays 0 and rf_r_wn stays 1 throughout; m0_ack=1 with m0_err=1, m0_rdata=0.
- Mask: m0 holds req high through ack with m1 idle -> second m0 grant occurs one cycle later than a fresh request would (4-cycle period); no duplicate grant in the IDLE cycle right after DONE.
- Reset mid-access: assert reset=0 during ACCESS of a write -> rf_r_wn=1 immediately (asynchronous), no ack, busy=0. After release, m0 wins the first contention.
